// File: rtl/cache_2way_ctrl.sv
// Miss-handling sequencer for a 2-way set-associative cache array: tag compare,
// victim read-out, dirty writeback, block refill and replay over a req/ack port.
//
// state     | meaning
// IDLE      | waiting for cpu_req; request registers open
// COMPARE   | tag lookup; hit completes, miss starts the fill
// VICTIM    | read out the way the array will replace
// WRITEBACK | dirty victim block written to memory
// REFILL    | requested block read from memory
// INSTALL   | fill buffer written into the victim way, then replay
module cache_2way_ctrl #(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 6,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  localparam int BW          = 32 * (1 << OFFSET_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_byte_w_en,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    c_enable,
  output logic                    c_cmp,
  output logic                    c_write,
  output logic                    c_valid_in,
  output logic [3:0]              c_byte_w_en,
  output logic [TAG_WIDTH-1:0]    c_tag_in,
  output logic [INDEX_WIDTH-1:0]  c_index,
  output logic [OFFSET_WIDTH-1:0] c_word_sel,
  output logic [31:0]             c_data_in,
  output logic [BW-1:0]           c_data_block_in,
  input  logic                    c_hit,
  input  logic                    c_dirty,
  input  logic                    c_valid_out,
  input  logic [TAG_WIDTH-1:0]    c_tag_out,
  input  logic [31:0]             c_data_out,
  input  logic [BW-1:0]           c_data_wb,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [BW-1:0]           mem_wdata,
  input  logic [BW-1:0]           mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int IDX_LSB = OFFSET_WIDTH + 2;
  localparam int TAG_LSB = 32 - TAG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_VICTIM, S_WRITEBACK, S_REFILL, S_INSTALL
  } state_t;

  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]    req_tag_q;
  logic [INDEX_WIDTH-1:0]  req_index_q;
  logic [OFFSET_WIDTH-1:0] req_word_q;
  logic                    req_we_q;
  logic [3:0]              req_be_q;
  logic [31:0]             req_wdata_q;
  logic                    first_cmp_q;
  logic [TAG_WIDTH-1:0]    vic_tag_q;
  logic [BW-1:0]           vic_data_q;
  logic [BW-1:0]           fill_q;
  logic [31:0]             rdata_q;
  logic                    ready_q;
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cpu_req) state_d = S_COMPARE;
      S_COMPARE:   state_d = c_hit ? S_IDLE : S_VICTIM;
      S_VICTIM:    state_d = (c_valid_out && c_dirty) ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (mem_ack) state_d = S_REFILL;
      S_REFILL:    if (mem_ack) state_d = S_INSTALL;
      S_INSTALL:   state_d = S_COMPARE;
      default:     state_d = S_IDLE;
    endcase
  end

  // c_cmp stays low from VICTIM to INSTALL so the array keeps the same victim way.
  always_comb begin
    c_enable        = 1'b0;
    c_cmp           = 1'b0;
    c_write         = 1'b0;
    c_valid_in      = 1'b0;
    c_byte_w_en     = 4'h0;
    c_tag_in        = '0;
    c_index         = '0;
    c_word_sel      = '0;
    c_data_in       = '0;
    c_data_block_in = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    if (state_q != S_IDLE) begin
      c_tag_in   = req_tag_q;
      c_index    = req_index_q;
      c_word_sel = req_word_q;
    end
    case (state_q)
      S_COMPARE: begin
        c_enable    = 1'b1;
        c_cmp       = 1'b1;
        c_write     = req_we_q;
        c_byte_w_en = req_be_q;
        c_data_in   = req_wdata_q;
      end
      S_VICTIM: c_enable = 1'b1;
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, req_index_q, {(OFFSET_WIDTH+2){1'b0}}};
        mem_wdata = vic_data_q;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, req_index_q, {(OFFSET_WIDTH+2){1'b0}}};
      end
      S_INSTALL: begin
        c_enable        = 1'b1;
        c_write         = 1'b1;
        c_valid_in      = 1'b1;
        c_byte_w_en     = 4'hF;
        c_data_block_in = fill_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_word_q  <= '0;
      req_we_q    <= 1'b0;
      req_be_q    <= 4'h0;
      req_wdata_q <= '0;
      first_cmp_q <= 1'b0;
      vic_tag_q   <= '0;
      vic_data_q  <= '0;
      fill_q      <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cpu_req) begin
          req_tag_q   <= cpu_addr[31:TAG_LSB];
          req_index_q <= cpu_addr[IDX_LSB +: INDEX_WIDTH];
          req_word_q  <= cpu_addr[IDX_LSB-1:2];
          req_we_q    <= cpu_we;
          req_be_q    <= cpu_byte_w_en;
          req_wdata_q <= cpu_wdata;
          first_cmp_q <= 1'b1;
        end
        S_COMPARE: begin
          first_cmp_q <= 1'b0;
          if (c_hit) begin
            ready_q <= 1'b1;
            if (!req_we_q) rdata_q <= c_data_out;
            // the replay after a fill is not a second hit
            if (first_cmp_q) hit_cnt_q <= hit_cnt_q + 32'd1;
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
        S_VICTIM: begin
          vic_tag_q  <= c_tag_out;
          vic_data_q <= c_data_wb;
        end
        S_REFILL: if (mem_ack) fill_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign cpu_ready  = ready_q;
  assign cpu_rdata  = rdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Bench for cache_2way_ctrl: behavioural 2-way array and memory around the DUT,
// checked against a per-set LRU list model and a flat CPU-view memory image.
module tb_cache_2way_ctrl;
  localparam int OW = 3, IW = 6, TW = 21, BW = 256;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0] cpu_byte_w_en, c_byte_w_en;
  logic c_enable, c_cmp, c_write, c_valid_in;
  logic [TW-1:0] c_tag_in, c_tag_out;
  logic [IW-1:0] c_index;
  logic [OW-1:0] c_word_sel;
  logic [31:0] c_data_in, c_data_out;
  logic [BW-1:0] c_data_block_in, c_data_wb;
  logic c_hit, c_dirty, c_valid_out;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_2way_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_byte_w_en(cpu_byte_w_en), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .c_enable(c_enable), .c_cmp(c_cmp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_byte_w_en(c_byte_w_en), .c_tag_in(c_tag_in), .c_index(c_index),
    .c_word_sel(c_word_sel), .c_data_in(c_data_in), .c_data_block_in(c_data_block_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid_out(c_valid_out),
    .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_data_wb(c_data_wb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing DRAM and the CPU-visible memory image, word-indexed by addr[13:2].
  logic [31:0] dram [4096];
  logic [31:0] view [4096];

  function automatic logic [BW-1:0] view_block(input logic [31:0] a);
    logic [BW-1:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = view[int'(a[13:2]) + k];
    return r;
  endfunction

  // Behavioural cache array: invalid way first, else least recently hit.
  logic [TW-1:0] a_tag [64][2];
  bit            a_valid [64][2];
  bit            a_dirty [64][2];
  logic [31:0]   a_data [64][2][8];
  bit            a_lru [64];

  function automatic int vway(input int s);
    if (!a_valid[s][0]) return 0;
    if (!a_valid[s][1]) return 1;
    return int'(a_lru[s]);
  endfunction

  initial begin : array_model
    int s, v, hw;
    for (int i = 0; i < 64; i++) begin
      a_valid[i][0] = 0; a_valid[i][1] = 0; a_lru[i] = 0;
      a_dirty[i][0] = 0; a_dirty[i][1] = 0;
    end
    c_hit = 0; c_dirty = 0; c_valid_out = 0; c_tag_out = '0; c_data_out = '0; c_data_wb = '0;
    forever begin
      @(posedge clk); #1;
      c_hit = 0; c_dirty = 0; c_valid_out = 0; c_tag_out = '0; c_data_out = '0; c_data_wb = '0;
      if (c_enable === 1'b1) begin
        s = int'(c_index);
        if (c_cmp) begin
          for (int w = 0; w < 2; w++)
            if (a_valid[s][w] && a_tag[s][w] == c_tag_in) begin
              c_hit = 1; c_valid_out = 1; c_dirty = a_dirty[s][w]; c_tag_out = a_tag[s][w];
              c_data_out = a_data[s][w][c_word_sel];
            end
        end else begin
          v = vway(s);
          c_valid_out = a_valid[s][v]; c_dirty = a_dirty[s][v]; c_tag_out = a_tag[s][v];
          for (int k = 0; k < 8; k++) c_data_wb[32*k +: 32] = a_data[s][v][k];
        end
      end
      @(negedge clk);
      if (c_enable === 1'b1) begin
        s = int'(c_index);
        if (c_cmp) begin
          hw = -1;
          for (int w = 0; w < 2; w++) if (a_valid[s][w] && a_tag[s][w] == c_tag_in) hw = w;
          if (hw >= 0) begin
            a_lru[s] = (hw == 0);
            if (c_write) begin
              for (int b = 0; b < 4; b++)
                if (c_byte_w_en[b]) a_data[s][hw][c_word_sel][8*b +: 8] = c_data_in[8*b +: 8];
              a_dirty[s][hw] = 1;
            end
          end
        end else if (c_write) begin
          v = vway(s);
          a_tag[s][v] = c_tag_in; a_valid[s][v] = c_valid_in; a_dirty[s][v] = 0;
          for (int k = 0; k < 8; k++) a_data[s][v][k] = c_data_block_in[32*k +: 32];
        end
      end
    end
  end

  // Memory responder: ack after ack_delay extra cycles (-1 = random 0..3).
  int ack_delay = 0;
  bit ack_always = 0;
  int req_cycles = 0;
  logic [31:0] last_wb_word0 = '0;
  logic [32:0] txq[$];

  initial begin : mem_model
    bit busy, chk_drop;
    int wait_left;
    logic [31:0] t_addr;
    logic t_we;
    logic [BW-1:0] t_wdata;
    busy = 0; chk_drop = 0; wait_left = 0;
    mem_ack = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = ack_always;
      if (chk_drop) chk("req_after_refill_ack", mem_req, 0);
      chk_drop = 0;
      if (mem_req !== 1'b1) busy = 0;
      else begin
        req_cycles++;
        if (!busy) begin
          busy = 1; t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
          wait_left = ack_always ? 0 : (ack_delay < 0 ? int'($urandom_range(0, 3)) : ack_delay);
          txq.push_back({mem_we, mem_addr});
          chk("mem_addr_align", mem_addr[4:0], 0);
          if (mem_we) begin
            last_wb_word0 = mem_wdata[31:0];
            chk("wb_block_data", mem_wdata, view_block(mem_addr));
          end
        end else begin
          chk("mem_hold_addr", {mem_we, mem_addr}, {t_we, t_addr});
          chk("mem_hold_wdata", mem_wdata, t_wdata);
        end
        if (wait_left == 0) begin
          mem_ack = 1;
          if (t_we) for (int k = 0; k < 8; k++) dram[int'(t_addr[13:2]) + k] = t_wdata[32*k +: 32];
          else begin
            for (int k = 0; k < 8; k++) mem_rdata[32*k +: 32] = dram[int'(t_addr[13:2]) + k];
            chk_drop = 1;
          end
          busy = 0;
        end else wait_left--;
      end
    end
  end

  // Reference: per-set LRU list (index 0 = most recent) of {tag, dirty}.
  int r_tag [64][2];
  bit r_dirty [64][2];
  int r_cnt [64];
  int exp_hits = 0, exp_misses = 0;
  logic [31:0] exp_rdata = '0;
  logic [32:0] exp_tx[$];

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, output int lat);
    int s, t, wi, pos;
    bit d;
    s = int'(addr[10:5]); t = int'(addr[31:11]); wi = int'(addr[13:2]);
    pos = -1;
    exp_tx.delete();
    for (int i = 0; i < r_cnt[s]; i++) if (r_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      exp_hits++;
      d = r_dirty[s][pos] | we;
      if (pos == 1) begin r_tag[s][1] = r_tag[s][0]; r_dirty[s][1] = r_dirty[s][0]; end
      r_tag[s][0] = t; r_dirty[s][0] = d;
    end else begin
      exp_misses++;
      if (r_cnt[s] == 2 && r_dirty[s][1])
        exp_tx.push_back({1'b1, 32'((r_tag[s][1] << 11) | (s << 5))});
      if (r_cnt[s] >= 1) begin r_tag[s][1] = r_tag[s][0]; r_dirty[s][1] = r_dirty[s][0]; end
      r_tag[s][0] = t; r_dirty[s][0] = we;
      if (r_cnt[s] < 2) r_cnt[s]++;
      exp_tx.push_back({1'b0, addr & 32'hFFFF_FFE0});
    end
    txq.delete();
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_byte_w_en = be; cpu_wdata = wdata;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin lat = c; break; end
    end
    cpu_req = 0;
    if (lat == 0) chk("cpu_ready_timeout", cpu_ready, 1);
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) view[wi][8*b +: 8] = wdata[8*b +: 8];
    end else exp_rdata = view[wi];
    chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("txn_count", txq.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++) chk("txn_kind_addr", txq[i], exp_tx[i]);
  endtask

  initial begin : main
    int lat, rc0, sel;
    logic [31:0] ra;
    bit found;
    for (int i = 0; i < 4096; i++) dram[i] = (i * 32'h9E3779B1) ^ 32'h0BADF00D;
    dram[12'h410] = 32'hDEADBEEF;
    dram[12'h820] = 32'h11112222;
    for (int i = 0; i < 4096; i++) view[i] = dram[i];
    for (int i = 0; i < 64; i++) r_cnt[i] = 0;
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_byte_w_en = '0; cpu_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_c_ctrl", {c_enable, c_cmp, c_write, c_valid_in, c_byte_w_en}, 0);
    chk("rst_c_fields", {c_tag_in, c_index, c_word_sel, c_data_in}, 0);
    chk("rst_c_block", c_data_block_in, 0);
    chk("rst_mem_ctrl", {mem_req, mem_we, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_counters", {hit_count, miss_count}, 0);
    rst = 0;

    ack_delay = 3;
    do_access(32'h0000_1040, 0, 4'h0, 32'h0, lat);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_miss_latency", lat, 9);
    do_access(32'h0000_1040, 0, 4'h0, 32'h0, lat);
    chk("t2_hit_latency", lat, 2);

    ack_delay = 1;
    do_access(32'h0000_1040, 1, 4'hF, 32'h1234_5678, lat);
    chk("t3_store_hit_latency", lat, 2);
    do_access(32'h0000_1840, 0, 4'h0, 32'h0, lat);
    do_access(32'h0000_2040, 0, 4'h0, 32'h0, lat);
    chk("t3_wb_first", txq[0], {1'b1, 32'h0000_1040});
    chk("t3_wb_word0", last_wb_word0, 32'h1234_5678);

    do_access(32'h0000_2080, 1, 4'b0011, 32'hAAAA_5555, lat);
    do_access(32'h0000_2080, 0, 4'h0, 32'h0, lat);
    chk("t4_merged_load", cpu_rdata, 32'h1111_5555);

    ack_delay = 10;
    txq.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_30C0; cpu_byte_w_en = 4'h0;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_we) begin found = 1; break; end
    end
    chk("t5_refill_seen", found, 1);
    @(posedge clk); #1;
    chk("t5_refill_still_req", {mem_req, mem_addr}, {1'b1, 32'h0000_30C0});
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    chk("t5_rst_mem_req", {mem_req, mem_we, mem_addr}, 0);
    chk("t5_rst_idle", {c_enable, cpu_ready}, 0);
    chk("t5_rst_counters", {hit_count, miss_count}, 0);
    rst = 0;
    exp_hits = 0; exp_misses = 0; exp_rdata = '0;
    ack_delay = 1;
    do_access(32'h0000_30C0, 0, 4'h0, 32'h0, lat);
    chk("t5_reload_miss", miss_count, 1);

    ack_always = 1;
    rc0 = req_cycles;
    do_access(32'h0000_38C0, 0, 4'h0, 32'h0, lat);
    chk("t6_clean_miss_latency", lat, 6);
    chk("t6_clean_req_cycles", req_cycles - rc0, 1);
    do_access(32'h0000_38C4, 0, 4'h0, 32'h0, lat);
    chk("t6_b2b_hit1", lat, 2);
    do_access(32'h0000_38C8, 0, 4'h0, 32'h0, lat);
    chk("t6_b2b_hit2", lat, 2);
    do_access(32'h0000_38C0, 1, 4'hF, 32'hCAFE_0001, lat);
    chk("t6_b2b_store", lat, 2);
    rc0 = req_cycles;
    do_access(32'h0000_28C0, 0, 4'h0, 32'h0, lat);
    chk("t6_evict_clean_latency", lat, 6);
    rc0 = req_cycles;
    do_access(32'h0000_30C0, 0, 4'h0, 32'h0, lat);
    chk("t6_dirty_miss_latency", lat, 7);
    chk("t6_dirty_req_cycles", req_cycles - rc0, 2);
    ack_always = 0;

    ack_delay = -1;
    for (int n = 0; n < 300; n++) begin
      ra = {18'h0, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), 3'($urandom), 2'b00};
      sel = int'($urandom_range(0, 2));
      do_access(ra, sel == 0, 4'($urandom), $urandom, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("ready_one_cycle", cpu_ready, 0);
        chk("idle_quiet", {c_enable, mem_req}, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
